// File: rtl/dcache_pkg.sv
// dcache_pkg: shared FSM state type, address-split helpers and the line record
// used by the set-associative data cache (dcache_sa) and its way storage.
package dcache_pkg;

  localparam int ADDR_W   = 32;
  // Upper bounds for the generic line record; each configuration uses the low bits.
  localparam int TAG_MAX  = 32;
  localparam int LINE_MAX = 1024;

  typedef enum logic [1:0] {
    LOOKUP    = 2'd0,
    WRITEBACK = 2'd1,
    REFILL    = 2'd2
  } state_e;

  // Byte-offset bits inside a line of 32-bit words.
  function automatic int offset_bits(input int line_words);
    return $clog2(line_words * 4);
  endfunction

  // Set-index bits.
  function automatic int index_bits(input int sets);
    return $clog2(sets);
  endfunction

  // Whatever the offset and index do not use is tag.
  function automatic int tag_bits(input int sets, input int line_words);
    return ADDR_W - index_bits(sets) - offset_bits(line_words);
  endfunction

  // Word-select bits inside a line (kept at least one bit wide).
  function automatic int word_sel_bits(input int line_words);
    return (line_words > 1) ? $clog2(line_words) : 1;
  endfunction

  typedef struct packed {
    logic                valid;
    logic                dirty;
    logic [TAG_MAX-1:0]  tag;
    logic [LINE_MAX-1:0] data;
  } line_t;

endpackage

// File: rtl/dcache_way.sv
// dcache_way: one way of the cache - tag, data, valid and dirty storage for
// every set, plus the tag compare for the currently indexed set.
module dcache_way
  import dcache_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int SETS       = 4,
  parameter int LINE_WORDS = 4
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [index_bits(SETS)-1:0]               index_i,
  input  logic [tag_bits(SETS, LINE_WORDS)-1:0]     tag_i,
  output logic                                      hit_o,
  output line_t                                     line_o,
  input  logic                                      store_en_i,
  input  logic [word_sel_bits(LINE_WORDS)-1:0]      store_word_i,
  input  logic [DATA_WIDTH/8-1:0]                   store_be_i,
  input  logic [DATA_WIDTH-1:0]                     store_data_i,
  input  logic                                      fill_en_i,
  input  logic [DATA_WIDTH*LINE_WORDS-1:0]          fill_data_i
);

  localparam int TAG_W     = tag_bits(SETS, LINE_WORDS);
  localparam int LINE_BITS = DATA_WIDTH * LINE_WORDS;
  localparam int BYTES     = DATA_WIDTH / 8;

  logic [TAG_W-1:0]     tag_q  [SETS];
  logic [LINE_BITS-1:0] data_q [SETS];
  logic [SETS-1:0]      valid_q;
  logic [SETS-1:0]      dirty_q;

  // Valid/dirty are the only per-line state with a defined reset value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fill_en_i) begin
      valid_q[index_i] <= 1'b1;
      dirty_q[index_i] <= 1'b0;
    end else if (store_en_i) begin
      dirty_q[index_i] <= 1'b1;
    end
  end

  // Tag/data arrays: a refill replaces the whole line, a store merges enabled byte lanes.
  always_ff @(posedge clk) begin
    if (fill_en_i) begin
      tag_q[index_i]  <= tag_i;
      data_q[index_i] <= fill_data_i;
    end else if (store_en_i) begin
      for (int b = 0; b < BYTES; b++) begin
        if (store_be_i[b]) begin
          data_q[index_i][int'(store_word_i)*DATA_WIDTH + b*8 +: 8] <= store_data_i[b*8 +: 8];
        end
      end
    end
  end

  // Present the indexed line and compare its tag against the request.
  always_comb begin
    line_o                     = '0;
    line_o.valid               = valid_q[index_i];
    line_o.dirty               = dirty_q[index_i];
    line_o.tag[TAG_W-1:0]      = tag_q[index_i];
    line_o.data[LINE_BITS-1:0] = data_q[index_i];
    hit_o                      = valid_q[index_i] && (tag_q[index_i] == tag_i);
  end

endmodule

// File: rtl/dcache_sa.sv
// dcache_sa: write-back, write-allocate set-associative data cache with a
// LOOKUP / WRITEBACK / REFILL miss FSM and round-robin replacement.
// Optional feature: define DCACHE_STATS_EN to add hit_count/miss_count outputs.
module dcache_sa
  import dcache_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int SETS       = 4,
  parameter int WAYS       = 2,
  parameter int LINE_WORDS = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           req_valid,
  input  logic                           MemWrite,
  input  logic                           AddrMode,
  input  logic [31:0]                    data_address,
  input  logic [DATA_WIDTH-1:0]          write_data,
  output logic [DATA_WIDTH-1:0]          read_data,
  output logic                           stall,
  output logic                           mem_req,
  output logic                           WriteEnable,
  output logic [31:0]                    memory_address,
  output logic [DATA_WIDTH*LINE_WORDS-1:0] mem_writedata,
  input  logic [DATA_WIDTH*LINE_WORDS-1:0] mem_readdata,
  input  logic                           mem_ready
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]                    hit_count,
  output logic [31:0]                    miss_count
`endif
);

  localparam int LINE_BITS = DATA_WIDTH * LINE_WORDS;
  localparam int OFF_W     = offset_bits(LINE_WORDS);
  localparam int IDX_W     = index_bits(SETS);
  localparam int TAG_W     = tag_bits(SETS, LINE_WORDS);
  localparam int WSEL_W    = word_sel_bits(LINE_WORDS);
  localparam int BYTES     = DATA_WIDTH / 8;
  localparam int WAY_W     = (WAYS > 1) ? $clog2(WAYS) : 1;

  state_e               state_q, state_d;
  logic [31:0]          miss_addr_q;
  logic [WAY_W-1:0]     vic_way_q, vic_way_d;
  logic                 retry_q;

  logic [31:0]          cur_addr;
  logic [IDX_W-1:0]     cur_idx;
  logic [TAG_W-1:0]     cur_tag;
  logic [WSEL_W-1:0]    word_sel;
  logic [1:0]           lane;

  logic [WAYS-1:0]      way_hit, way_store, way_fill;
  line_t                way_line [WAYS];
  line_t                vic_line;
  logic [WAY_W-1:0]     hit_way, rr_cur;
  logic                 hit_any, free_found;
  logic                 lookup_hit, miss, fill_done;
  logic [LINE_BITS-1:0] hit_data;
  logic [DATA_WIDTH-1:0] hit_word, store_data;
  logic [BYTES-1:0]     store_be;

  // While a miss is outstanding the captured address drives the arrays, so a
  // dropped or changed CPU request cannot disturb the transaction.
  assign cur_addr   = (state_q == LOOKUP) ? data_address : miss_addr_q;
  assign cur_idx    = cur_addr[OFF_W +: IDX_W];
  assign cur_tag    = cur_addr[ADDR_W-1 -: TAG_W];
  assign word_sel   = data_address[OFF_W-1:2];
  assign lane       = data_address[1:0];

  assign lookup_hit = (state_q == LOOKUP) && req_valid && hit_any;
  assign miss       = (state_q == LOOKUP) && req_valid && !hit_any;
  assign fill_done  = (state_q == REFILL) && mem_ready;

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    assign way_store[w] = lookup_hit && MemWrite && way_hit[w];
    assign way_fill[w]  = fill_done && (vic_way_q == WAY_W'(w));

    dcache_way #(
      .DATA_WIDTH (DATA_WIDTH),
      .SETS       (SETS),
      .LINE_WORDS (LINE_WORDS)
    ) u_way (
      .clk          (clk),
      .rst          (rst),
      .index_i      (cur_idx),
      .tag_i        (cur_tag),
      .hit_o        (way_hit[w]),
      .line_o       (way_line[w]),
      .store_en_i   (way_store[w]),
      .store_word_i (word_sel),
      .store_be_i   (store_be),
      .store_data_i (store_data),
      .fill_en_i    (way_fill[w]),
      .fill_data_i  (mem_readdata)
    );
  end

  if (WAYS > 1) begin : g_rr
    logic [WAY_W-1:0] rr_q [SETS];

    // Per-set round-robin pointer, stepped on every completed refill of that set.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int s = 0; s < SETS; s++) rr_q[s] <= '0;
      end else if (fill_done) begin
        rr_q[cur_idx] <= rr_q[cur_idx] + WAY_W'(1);
      end
    end

    assign rr_cur = rr_q[cur_idx];
  end else begin : g_no_rr
    assign rr_cur = '0;
  end

  // Byte stores replicate the byte onto every lane and enable only the addressed one.
  always_comb begin
    store_data = write_data;
    store_be   = '1;
    if (AddrMode) begin
      store_data = {BYTES{write_data[7:0]}};
      store_be   = BYTES'(1) << lane;
    end
  end

  // Pick the hitting way and the addressed word out of its line.
  always_comb begin
    hit_any = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (way_hit[w]) begin
        hit_any = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
    hit_data = way_line[hit_way].data[LINE_BITS-1:0];
    hit_word = hit_data[int'(word_sel)*DATA_WIDTH +: DATA_WIDTH];
  end

  // Victim: lowest-numbered invalid way, otherwise the set's round-robin pointer.
  always_comb begin
    vic_way_d  = rr_cur;
    free_found = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (!free_found && !way_line[w].valid) begin
        vic_way_d  = WAY_W'(w);
        free_found = 1'b1;
      end
    end
    vic_line = way_line[(state_q == LOOKUP) ? vic_way_d : vic_way_q];
  end

  // Load data: the hit word or its zero-extended byte, zero when nothing hits.
  always_comb begin
    read_data = '0;
    if (lookup_hit && !MemWrite) begin
      read_data = AddrMode ? DATA_WIDTH'(hit_word[int'(lane)*8 +: 8]) : hit_word;
    end
  end

  // FSM state register plus the miss context captured when the miss is seen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= LOOKUP;
      miss_addr_q <= '0;
      vic_way_q   <= '0;
      retry_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      retry_q <= fill_done;
      if (miss) begin
        miss_addr_q <= data_address;
        vic_way_q   <= vic_way_d;
      end
    end
  end

  // FSM next state and memory-side outputs; reset forces the handshake quiet.
  always_comb begin
    state_d        = state_q;
    stall          = 1'b0;
    mem_req        = 1'b0;
    WriteEnable    = 1'b0;
    memory_address = '0;
    mem_writedata  = '0;
    case (state_q)
      LOOKUP: begin
        stall = miss;
        if (miss) begin
          state_d = (vic_line.valid && vic_line.dirty) ? WRITEBACK : REFILL;
        end
      end
      WRITEBACK: begin
        stall          = 1'b1;
        mem_req        = 1'b1;
        WriteEnable    = 1'b1;
        memory_address = {vic_line.tag[TAG_W-1:0], cur_idx, {OFF_W{1'b0}}};
        mem_writedata  = vic_line.data[LINE_BITS-1:0];
        if (mem_ready) state_d = REFILL;
      end
      REFILL: begin
        stall          = 1'b1;
        mem_req        = 1'b1;
        memory_address = {cur_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
        if (mem_ready) state_d = LOOKUP;
      end
      default: state_d = LOOKUP;
    endcase
    if (rst) begin
      stall       = 1'b0;
      mem_req     = 1'b0;
      WriteEnable = 1'b0;
    end
  end

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_count_q, miss_count_q;

  // Access statistics; the hit that completes a refilled miss is not a new hit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      if (lookup_hit && !retry_q) hit_count_q <= hit_count_q + 32'd1;
      if (miss) miss_count_q <= miss_count_q + 32'd1;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_dcache_sa.sv
// tb_dcache_sa: directed and randomized checks of dcache_sa against a
// behavioural model (CPU-visible memory image, backing memory, residency sets).
module tb_dcache_sa;

  localparam int SETS = 4;
  localparam int WAYS = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid, MemWrite, AddrMode, mem_ready;
  logic [31:0]  data_address, write_data, read_data, memory_address;
  logic         stall, mem_req, WriteEnable;
  logic [127:0] mem_writedata, mem_readdata;
`ifdef DCACHE_STATS_EN
  logic [31:0]  hit_count, miss_count;
`endif

  dcache_sa #(
    .DATA_WIDTH (32),
    .SETS       (SETS),
    .WAYS       (WAYS),
    .LINE_WORDS (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .MemWrite       (MemWrite),
    .AddrMode       (AddrMode),
    .data_address   (data_address),
    .write_data     (write_data),
    .read_data      (read_data),
    .stall          (stall),
    .mem_req        (mem_req),
    .WriteEnable    (WriteEnable),
    .memory_address (memory_address),
    .mem_writedata  (mem_writedata),
    .mem_readdata   (mem_readdata),
    .mem_ready      (mem_ready)
`ifdef DCACHE_STATS_EN
    ,
    .hit_count      (hit_count),
    .miss_count     (miss_count)
`endif
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  // Model: what the CPU should see, what backing memory holds, and which lines are resident.
  bit [31:0] gold [int];
  bit [31:0] back [int];
  bit        mValid [SETS][WAYS];
  bit        mDirty [SETS][WAYS];
  int        mTag   [SETS][WAYS];
  int        mRr    [SETS];
  int        mHits, mMisses;

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void ensureWord(input int wa);
    bit [31:0] v;
    if (!gold.exists(wa)) begin
      v = $urandom;
      gold[wa] = v;
      back[wa] = v;
    end
  endfunction

  function automatic logic [127:0] goldLine(input int lineAddr);
    logic [127:0] r;
    for (int i = 0; i < 4; i++) begin
      ensureWord((lineAddr >> 2) + i);
      r[i*32 +: 32] = gold[(lineAddr >> 2) + i];
    end
    return r;
  endfunction

  function automatic logic [127:0] backLine(input int lineAddr);
    logic [127:0] r;
    for (int i = 0; i < 4; i++) begin
      ensureWord((lineAddr >> 2) + i);
      r[i*32 +: 32] = back[(lineAddr >> 2) + i];
    end
    return r;
  endfunction

  function automatic logic [31:0] expRead(input bit [31:0] addr, input bit byteMode);
    bit [31:0] w;
    w = gold[int'(addr >> 2)];
    return byteMode ? ((w >> (int'(addr[1:0]) * 8)) & 32'hFF) : w;
  endfunction

  function automatic void applyStore(input bit [31:0] addr, input bit byteMode, input bit [31:0] wdata);
    int wa;
    int sh;
    wa = int'(addr >> 2);
    if (byteMode) begin
      sh = int'(addr[1:0]) * 8;
      gold[wa] = (gold[wa] & ~(32'hFF << sh)) | ({24'd0, wdata[7:0]} << sh);
    end else begin
      gold[wa] = wdata;
    end
  endfunction

  // Reset loses any dirty data, so the CPU-visible image falls back to backing memory.
  function automatic void resetModel();
    for (int s = 0; s < SETS; s++) begin
      mRr[s] = 0;
      for (int w = 0; w < WAYS; w++) begin
        mValid[s][w] = 1'b0;
        mDirty[s][w] = 1'b0;
        mTag[s][w]   = 0;
      end
    end
    foreach (back[k]) gold[k] = back[k];
    mHits   = 0;
    mMisses = 0;
  endfunction

  task automatic applyReset();
    rst          = 1'b1;
    req_valid    = 1'b1;
    data_address = $urandom & 32'h1FF;
    mem_ready    = 1'b1;
    #2;
    checkOutput("rst_stall", stall, 1'b0);
    checkOutput("rst_mem_req", mem_req, 1'b0);
    checkOutput("rst_we", WriteEnable, 1'b0);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    req_valid = 1'b0;
    mem_ready = 1'b0;
    resetModel();
  endtask

  task automatic applyIdle();
    req_valid    = 1'b0;
    MemWrite     = 1'($urandom);
    AddrMode     = 1'($urandom);
    data_address = $urandom & 32'h1FF;
    mem_ready    = 1'($urandom);
    @(negedge clk);
    checkOutput("idle_stall", stall, 1'b0);
    checkOutput("idle_mem_req", mem_req, 1'b0);
    checkOutput("idle_read_data", read_data, 32'd0);
    @(posedge clk);
    #1;
    mem_ready = 1'b0;
  endtask

  // One CPU access, including any writeback/refill handshake the model predicts.
  task automatic applyStimulus(input bit wr, input bit byteMode, input bit [31:0] addr,
                               input bit [31:0] wdata, input int lat1, input int lat2,
                               input bit dropValid);
    int  set, tag, lineAddr, hitWay, vic, vAddr;
    logic [127:0] expWb;
    set      = int'((addr >> 4) & 32'h3);
    tag      = int'(addr >> 6);
    lineAddr = int'(addr & ~32'hF);
    hitWay   = -1;
    for (int w = 0; w < WAYS; w++) if (mValid[set][w] && mTag[set][w] == tag) hitWay = w;

    req_valid    = 1'b1;
    MemWrite     = wr;
    AddrMode     = byteMode;
    data_address = addr;
    write_data   = wdata;
    mem_ready    = 1'($urandom);
    @(negedge clk);
    if (hitWay >= 0) begin
      checkOutput("hit_stall", stall, 1'b0);
      checkOutput("hit_mem_req", mem_req, 1'b0);
      if (!wr) checkOutput("hit_read_data", read_data, expRead(addr, byteMode));
      @(posedge clk);
      #1;
      if (wr) begin
        applyStore(addr, byteMode, wdata);
        mDirty[set][hitWay] = 1'b1;
      end
      mHits++;
    end else begin
      checkOutput("miss_stall", stall, 1'b1);
      checkOutput("miss_mem_req", mem_req, 1'b0);
      mMisses++;
      vic = -1;
      for (int w = WAYS - 1; w >= 0; w--) if (!mValid[set][w]) vic = w;
      if (vic < 0) vic = mRr[set];
      @(posedge clk);
      #1;
      mem_ready = 1'b0;
      if (dropValid) req_valid = 1'b0;
      if (mValid[set][vic] && mDirty[set][vic]) begin
        vAddr = (mTag[set][vic] << 6) | (set << 4);
        expWb = goldLine(vAddr);
        for (int i = 0; i <= lat1; i++) begin
          mem_ready = (i == lat1);
          @(negedge clk);
          checkOutput("wb_mem_req", mem_req, 1'b1);
          checkOutput("wb_we", WriteEnable, 1'b1);
          checkOutput("wb_addr", memory_address, 32'(vAddr));
          checkOutput("wb_data", mem_writedata, expWb);
          checkOutput("wb_stall", stall, 1'b1);
          @(posedge clk);
          #1;
        end
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) back[(vAddr >> 2) + i] = expWb[i*32 +: 32];
      end
      for (int i = 0; i <= lat2; i++) begin
        mem_ready    = (i == lat2);
        mem_readdata = (i == lat2) ? backLine(lineAddr) : {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
        checkOutput("rf_mem_req", mem_req, 1'b1);
        checkOutput("rf_we", WriteEnable, 1'b0);
        checkOutput("rf_addr", memory_address, 32'(lineAddr));
        @(posedge clk);
        #1;
      end
      mem_ready        = 1'b0;
      mValid[set][vic] = 1'b1;
      mDirty[set][vic] = 1'b0;
      mTag[set][vic]   = tag;
      mRr[set]         = (mRr[set] + 1) % WAYS;
      @(negedge clk);
      checkOutput("retry_stall", stall, 1'b0);
      checkOutput("retry_mem_req", mem_req, 1'b0);
      if (dropValid) checkOutput("drop_read_data", read_data, 32'd0);
      else if (!wr) checkOutput("retry_read_data", read_data, expRead(addr, byteMode));
      @(posedge clk);
      #1;
      if (wr && !dropValid) begin
        applyStore(addr, byteMode, wdata);
        mDirty[set][vic] = 1'b1;
      end
    end
    req_valid = 1'b0;
  endtask

  initial begin
    bit [31:0] a;
    bit        wr, bm;
    int        kind;
    rst          = 1'b1;
    req_valid    = 1'b0;
    MemWrite     = 1'b0;
    AddrMode     = 1'b0;
    data_address = '0;
    write_data   = '0;
    mem_ready    = 1'b0;
    mem_readdata = '0;
    resetModel();
    applyReset();
    applyIdle();

    $display("[TB] directed sequence");
    gold[4] = 32'hDEADBEEF;
    back[4] = 32'hDEADBEEF;
    applyStimulus(1'b0, 1'b0, 32'h10, 32'h0, 0, 3, 1'b0);
    applyStimulus(1'b1, 1'b1, 32'h13, 32'h000000AB, 0, 0, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h10, 32'h0, 0, 0, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h50, 32'h0, 0, 1, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h90, 32'h0, 2, 0, 1'b0);
    applyStimulus(1'b0, 1'b1, 32'h92, 32'h0, 0, 0, 1'b0);
`ifdef DCACHE_STATS_EN
    @(negedge clk);
    checkOutput("stats_hit_count", hit_count, 32'd3);
    checkOutput("stats_miss_count", miss_count, 32'd3);
    @(posedge clk);
    #1;
`endif
    applyIdle();

    $display("[TB] reset during refill");
    req_valid    = 1'b1;
    MemWrite     = 1'b0;
    AddrMode     = 1'b0;
    data_address = 32'h2A0;
    mem_ready    = 1'b0;
    @(negedge clk);
    checkOutput("r53_stall", stall, 1'b1);
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("r53_mem_req", mem_req, 1'b1);
    checkOutput("r53_addr", memory_address, 32'h2A0);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("r53_mem_req_drop", mem_req, 1'b0);
    checkOutput("r53_stall_drop", stall, 1'b0);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    req_valid = 1'b0;
    resetModel();
    applyStimulus(1'b0, 1'b0, 32'h10, 32'h0, 0, 1, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h2A0, 32'h0, 0, 0, 1'b0);

    $display("[TB] randomized accesses");
    for (int n = 0; n < 400; n++) begin
      kind = $urandom_range(0, 39);
      if (kind < 4) begin
        applyIdle();
      end else if (kind == 4) begin
        applyReset();
      end else begin
        wr = 1'($urandom);
        bm = 1'($urandom);
        a  = $urandom & 32'h1FF;
        if (!bm) a = a & ~32'h3;
        applyStimulus(wr, bm, a, $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
                      ($urandom_range(0, 7) == 0));
      end
    end
`ifdef DCACHE_STATS_EN
    @(negedge clk);
    checkOutput("stats_hit_final", hit_count, 32'(mHits));
    checkOutput("stats_miss_final", miss_count, 32'(mMisses));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
